pu_mult_arbiter: RTL and testbench

- Shares one pu_mult instance between NUM_REQ client requesters using round-robin arbitration.
- Per operation: latches the winner's two operands, drives the PU write sequence (sel=0 then sel=1), waits a fixed latency, pulses signal_oe, captures the result, and returns it tagged with the requester id.
- Sits between pu_mult and its client datapaths, for example two filter stages sharing one multiplier.

---
 rtl/pu_mult_arbiter_if.sv | 39 +++
 rtl/pu_mult_arbiter.sv | 156 +++++++++++++++
 tb/tb_pu_mult_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pu_mult_arbiter_if.sv
// Client request/response and pu_mult control signals of the shared-multiplier arbiter.
// master = the arbiter, slave = the clients plus the pu_mult instance.
interface pu_mult_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ATTR_WIDTH = 4,
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ID_WIDTH   = 3
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ*ATTR_WIDTH-1:0] req_attr_a;
    logic [NUM_REQ*ATTR_WIDTH-1:0] req_attr_b;
    logic [NUM_REQ-1:0]            ack;
    logic                          resp_valid;
    logic [ID_WIDTH-1:0]           resp_id;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic [ATTR_WIDTH-1:0]         resp_attr;
    logic                          busy;
    logic [DATA_WIDTH-1:0]         pu_data_in;
    logic [ATTR_WIDTH-1:0]         pu_attr_in;
    logic                          pu_signal_wr;
    logic                          pu_signal_sel;
    logic                          pu_signal_oe;
    logic [DATA_WIDTH-1:0]         pu_data_out;
    logic [ATTR_WIDTH-1:0]         pu_attr_out;

    modport master (
        input  req, req_a, req_b, req_attr_a, req_attr_b, pu_data_out, pu_attr_out,
        output ack, resp_valid, resp_id, resp_data, resp_attr, busy,
               pu_data_in, pu_attr_in, pu_signal_wr, pu_signal_sel, pu_signal_oe
    );

    modport slave (
        output req, req_a, req_b, req_attr_a, req_attr_b, pu_data_out, pu_attr_out,
        input  ack, resp_valid, resp_id, resp_data, resp_attr, busy,
               pu_data_in, pu_attr_in, pu_signal_wr, pu_signal_sel, pu_signal_oe
    );
endinterface

// File: rtl/pu_mult_arbiter.sv
// Round-robin arbiter sharing one pu_mult between NUM_REQ clients: loads A/B,
// waits the fixed multiplier latency, reads the product and returns it tagged with the client id.
module pu_mult_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ATTR_WIDTH   = 4,
    parameter int unsigned INVALID      = 0,
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned ID_WIDTH     = 3,
    parameter int unsigned MULT_LATENCY = 2
) (
    input logic             clk,
    input logic             rst,
    pu_mult_arbiter_if.master bus
);
    localparam int unsigned CNT_W = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("pu_mult_arbiter: NUM_REQ must be 2..8");
    end
    if ((1 << ID_WIDTH) < NUM_REQ) begin : g_bad_id_width
        $error("pu_mult_arbiter: ID_WIDTH cannot hold NUM_REQ-1");
    end
    if (MULT_LATENCY < 1) begin : g_bad_latency
        $error("pu_mult_arbiter: MULT_LATENCY must be at least 1");
    end
    if (INVALID >= ATTR_WIDTH) begin : g_bad_invalid
        $error("pu_mult_arbiter: INVALID must index into attr");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT, S_READ, S_RESP
    } state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   last_grant;
    logic [ID_WIDTH-1:0]   cur_id;
    logic [DATA_WIDTH-1:0] op_b;
    logic [ATTR_WIDTH-1:0] op_attr_b;
    logic [CNT_W-1:0]      wait_cnt;

    logic                  win;
    logic [ID_WIDTH-1:0]   win_id;
    logic [NUM_REQ-1:0]    win_onehot;
    logic [DATA_WIDTH-1:0] win_a;
    logic [DATA_WIDTH-1:0] win_b;
    logic [ATTR_WIDTH-1:0] win_attr_a;
    logic [ATTR_WIDTH-1:0] win_attr_b;
    int unsigned           pos;

    // Round-robin pick: first requester at or after last_grant+1, wrapping at NUM_REQ.
    always_comb begin
        win        = 1'b0;
        win_id     = '0;
        win_onehot = '0;
        win_a      = '0;
        win_b      = '0;
        win_attr_a = '0;
        win_attr_b = '0;
        pos        = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            pos = 32'(last_grant) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!win && pos == i && bus.req[i]) begin
                    win           = 1'b1;
                    win_id        = ID_WIDTH'(i);
                    win_onehot[i] = 1'b1;
                    win_a         = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
                    win_b         = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
                    win_attr_a    = bus.req_attr_a[i*ATTR_WIDTH +: ATTR_WIDTH];
                    win_attr_b    = bus.req_attr_b[i*ATTR_WIDTH +: ATTR_WIDTH];
                end
            end
        end
    end

    // Sequencer; outputs are registered one cycle ahead so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            last_grant        <= ID_WIDTH'(NUM_REQ - 1);
            cur_id            <= '0;
            op_b              <= '0;
            op_attr_b         <= '0;
            wait_cnt          <= '0;
            bus.ack           <= '0;
            bus.resp_valid    <= 1'b0;
            bus.resp_id       <= '0;
            bus.resp_data     <= '0;
            bus.resp_attr     <= '0;
            bus.busy          <= 1'b0;
            bus.pu_data_in    <= '0;
            bus.pu_attr_in    <= '0;
            bus.pu_signal_wr  <= 1'b0;
            bus.pu_signal_sel <= 1'b0;
            bus.pu_signal_oe  <= 1'b0;
        end else begin
            bus.ack           <= '0;
            bus.resp_valid    <= 1'b0;
            bus.pu_data_in    <= '0;
            bus.pu_attr_in    <= '0;
            bus.pu_signal_wr  <= 1'b0;
            bus.pu_signal_sel <= 1'b0;
            bus.pu_signal_oe  <= 1'b0;
            case (state)
                S_IDLE, S_RESP: begin
                    if (win) begin
                        state            <= S_LOAD_A;
                        bus.busy         <= 1'b1;
                        last_grant       <= win_id;
                        cur_id           <= win_id;
                        op_b             <= win_b;
                        op_attr_b        <= win_attr_b;
                        bus.ack          <= win_onehot;
                        bus.pu_signal_wr <= 1'b1;
                        bus.pu_data_in   <= win_a;
                        bus.pu_attr_in   <= win_attr_a;
                    end else begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                S_LOAD_A: begin
                    state             <= S_LOAD_B;
                    bus.pu_signal_wr  <= 1'b1;
                    bus.pu_signal_sel <= 1'b1;
                    bus.pu_data_in    <= op_b;
                    bus.pu_attr_in    <= op_attr_b;
                end
                S_LOAD_B: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (wait_cnt == CNT_W'(MULT_LATENCY - 1)) begin
                        state            <= S_READ;
                        bus.pu_signal_oe <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_READ: begin
                    state          <= S_RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_id    <= cur_id;
                    bus.resp_data  <= bus.pu_data_out;
                    bus.resp_attr  <= bus.pu_attr_out;
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pu_mult_arbiter.sv
// Bench for pu_mult_arbiter: behavioural pu_mult, directed scenarios and random clients
// checked every cycle against a transaction-timeline reference model.
module tb_pu_mult_arbiter;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 4;
    localparam int unsigned NR   = 2;
    localparam int unsigned IW   = 3;
    localparam int unsigned L    = 2;
    localparam int unsigned INV  = 0;
    localparam int          RING = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pu_mult_arbiter_if #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .NUM_REQ(NR), .ID_WIDTH(IW)) bus ();

    pu_mult_arbiter #(
        .DATA_WIDTH(DW), .ATTR_WIDTH(AW), .INVALID(INV),
        .NUM_REQ(NR), .ID_WIDTH(IW), .MULT_LATENCY(L)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Client drive values
    logic [NR-1:0] cl_req;
    logic [DW-1:0] cl_a  [NR];
    logic [DW-1:0] cl_b  [NR];
    logic [AW-1:0] cl_aa [NR];
    logic [AW-1:0] cl_ab [NR];

    always_comb begin
        bus.req        = cl_req;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_attr_a = '0;
        bus.req_attr_b = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*DW +: DW]      = cl_a[i];
            bus.req_b[i*DW +: DW]      = cl_b[i];
            bus.req_attr_a[i*AW +: AW] = cl_aa[i];
            bus.req_attr_b[i*AW +: AW] = cl_ab[i];
        end
    end

    function automatic logic [DW-1:0] mul_lo(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return DW'(p);
    endfunction

    // Behavioural pu_mult: sel=0 loads A, sel=1 loads B, result visible while oe is high
    logic [DW-1:0] pu_a, pu_b;
    logic [AW-1:0] pu_aa, pu_ab;
    always @(posedge clk) begin
        if (rst) begin
            pu_a <= '0; pu_b <= '0; pu_aa <= '0; pu_ab <= '0;
        end else if (bus.pu_signal_wr) begin
            if (!bus.pu_signal_sel) begin
                pu_a <= bus.pu_data_in; pu_aa <= bus.pu_attr_in;
            end else begin
                pu_b <= bus.pu_data_in; pu_ab <= bus.pu_attr_in;
            end
        end
    end
    assign bus.pu_data_out = bus.pu_signal_oe ? mul_lo(pu_a, pu_b) : '0;
    assign bus.pu_attr_out = bus.pu_signal_oe ? (pu_aa | pu_ab) : '0;

    // Reference model: per-cycle expected outputs scheduled on a timeline
    typedef struct packed {
        logic [NR-1:0] ack;
        logic          wr;
        logic          sel;
        logic [DW-1:0] din;
        logic [AW-1:0] ain;
        logic          oe;
        logic          rv;
        logic          busy;
        logic          clr;
        logic [IW-1:0] rid;
        logic [DW-1:0] rdata;
        logic [AW-1:0] rattr;
    } exp_t;

    exp_t          ring [RING];
    int            cyc = 0;
    int            avail = 0;
    int            last_g = NR - 1;
    logic [IW-1:0] h_rid;
    logic [DW-1:0] h_rdata;
    logic [AW-1:0] h_rattr;

    int n_checks = 0;
    int n_errors = 0;

    // Observations
    logic [NR-1:0] obs_ack;
    int            n_ack [NR];
    int            n_resp = 0;
    int            grants[$];
    int            grant_cyc[$];
    logic [DW-1:0] rdata_by_id [NR];
    logic [AW-1:0] rattr_by_id [NR];
    logic [DW-1:0] last_rdata;
    logic [AW-1:0] last_rattr;
    logic [IW-1:0] last_rid;
    int            last_resp_cyc = 0;
    int            last_ack_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int ri(input int c);
        return c % RING;
    endfunction

    // Called right after each rising edge with the inputs the DUT just sampled
    task automatic model_step();
        int w;
        int p;
        if (rst) begin
            for (int k = 0; k < RING; k++) ring[k] = '0;
            last_g = NR - 1;
            avail  = cyc + 1;
            ring[ri(cyc + 1)].clr = 1'b1;
        end else if (cyc >= avail && cl_req != '0) begin
            w = -1;
            for (int k = 1; k <= NR; k++) begin
                p = (last_g + k) % NR;
                if (w < 0 && cl_req[p]) w = p;
            end
            ring[ri(cyc + 1)].ack[w] = 1'b1;
            ring[ri(cyc + 1)].wr     = 1'b1;
            ring[ri(cyc + 1)].din    = cl_a[w];
            ring[ri(cyc + 1)].ain    = cl_aa[w];
            ring[ri(cyc + 2)].wr     = 1'b1;
            ring[ri(cyc + 2)].sel    = 1'b1;
            ring[ri(cyc + 2)].din    = cl_b[w];
            ring[ri(cyc + 2)].ain    = cl_ab[w];
            ring[ri(cyc + 3 + L)].oe    = 1'b1;
            ring[ri(cyc + 4 + L)].rv    = 1'b1;
            ring[ri(cyc + 4 + L)].rid   = IW'(w);
            ring[ri(cyc + 4 + L)].rdata = mul_lo(cl_a[w], cl_b[w]);
            ring[ri(cyc + 4 + L)].rattr = cl_aa[w] | cl_ab[w];
            for (int k = 1; k <= 4 + L; k++) ring[ri(cyc + k)].busy = 1'b1;
            last_g = w;
            avail  = cyc + 4 + L;
        end
        cyc++;
    endtask

    task automatic check_cycle();
        exp_t e;
        e = ring[ri(cyc)];
        if (e.clr) begin
            h_rid = '0; h_rdata = '0; h_rattr = '0;
        end
        if (e.rv) begin
            h_rid = e.rid; h_rdata = e.rdata; h_rattr = e.rattr;
        end
        check("ack",        64'(bus.ack),           64'(e.ack));
        check("pu_wr",      64'(bus.pu_signal_wr),  64'(e.wr));
        check("pu_sel",     64'(bus.pu_signal_sel), 64'(e.sel));
        check("pu_data_in", 64'(bus.pu_data_in),    64'(e.din));
        check("pu_attr_in", 64'(bus.pu_attr_in),    64'(e.ain));
        check("pu_oe",      64'(bus.pu_signal_oe),  64'(e.oe));
        check("resp_valid", 64'(bus.resp_valid),    64'(e.rv));
        check("busy",       64'(bus.busy),          64'(e.busy));
        check("resp_id",    64'(bus.resp_id),       64'(h_rid));
        check("resp_data",  64'(bus.resp_data),     64'(h_rdata));
        check("resp_attr",  64'(bus.resp_attr),     64'(h_rattr));
        ring[ri(cyc)] = '0;
    endtask

    task automatic observe();
        obs_ack = bus.ack;
        for (int i = 0; i < NR; i++) begin
            if (bus.ack[i]) begin
                n_ack[i]++;
                grants.push_back(i);
                grant_cyc.push_back(cyc);
                last_ack_cyc = cyc;
            end
        end
        if (bus.resp_valid) begin
            n_resp++;
            last_rdata    = bus.resp_data;
            last_rattr    = bus.resp_attr;
            last_rid      = bus.resp_id;
            last_resp_cyc = cyc;
            if (int'(bus.resp_id) < NR) begin
                rdata_by_id[bus.resp_id] = bus.resp_data;
                rattr_by_id[bus.resp_id] = bus.resp_attr;
            end
        end
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_step();
        #1;
        check_cycle();
        observe();
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [AW-1:0] aa, input logic [AW-1:0] ab);
        cl_a[i] = a; cl_b[i] = b; cl_aa[i] = aa; cl_ab[i] = ab;
        cl_req[i] = 1'b1;
    endtask

    task automatic wait_ack(input int i);
        int n;
        n = 0;
        do begin
            run_cycle();
            n++;
        end while (!obs_ack[i] && n < 40);
        check("ack_wait", 64'(obs_ack[i]), 64'(1));
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        do begin
            run_cycle();
            n++;
        end while (!bus.resp_valid && n < 40);
        check("resp_wait", 64'(bus.resp_valid), 64'(1));
    endtask

    task automatic run_idle(input int n);
        for (int k = 0; k < n; k++) run_cycle();
    endtask

    task automatic new_ops(input int i);
        cl_a[i] = $urandom;
        cl_b[i] = $urandom;
        if ($urandom_range(1, 0) == 1) cl_a[i] = DW'(int'($urandom_range(200, 0)) - 100);
        if ($urandom_range(1, 0) == 1) cl_b[i] = DW'(int'($urandom_range(200, 0)) - 100);
        cl_aa[i] = AW'($urandom_range(15, 0));
        cl_ab[i] = AW'($urandom_range(15, 0));
    endtask

    // Random clients obeying the hold-until-ack rule, with occasional early drops
    task automatic client_drive();
        for (int i = 0; i < NR; i++) begin
            if (cl_req[i] && obs_ack[i]) begin
                if ($urandom_range(1, 0) == 1) new_ops(i);
                else cl_req[i] = 1'b0;
            end else if (cl_req[i]) begin
                if ($urandom_range(99, 0) < 3) cl_req[i] = 1'b0;
            end else if ($urandom_range(99, 0) < 30) begin
                new_ops(i);
                cl_req[i] = 1'b1;
            end
        end
    endtask

    initial begin
        int snap;
        int idle_bad;
        int acks0;
        int resp0;
        cl_req = '0;
        obs_ack = '0;
        for (int i = 0; i < NR; i++) begin
            cl_a[i] = '0; cl_b[i] = '0; cl_aa[i] = '0; cl_ab[i] = '0;
            n_ack[i] = 0; rdata_by_id[i] = '0; rattr_by_id[i] = '0;
        end

        // Reset
        rst = 1'b1;
        run_idle(3);
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_ack", 64'(bus.ack), 64'(0));
        rst = 1'b0;
        run_cycle();

        // Single operation with fixed latency
        set_op(0, 32'd5, 32'h0010_0007, 4'h0, 4'h0);
        wait_ack(0);
        cl_req[0] = 1'b0;
        wait_resp();
        check("single_data", 64'(last_rdata), 64'(32'h0050_0023));
        check("single_id", 64'(last_rid), 64'(0));
        check("single_latency", 64'(last_resp_cyc - last_ack_cyc), 64'(5));

        // Signed operands from requester 1
        set_op(1, -32'sd10, -32'sd10, 4'h0, 4'h0);
        wait_ack(1);
        cl_req[1] = 1'b0;
        wait_resp();
        check("signed_data_100", 64'(last_rdata), 64'(32'd100));
        check("signed_id", 64'(last_rid), 64'(1));
        set_op(1, -32'sd4, 32'sd5, 4'h0, 4'h0);
        wait_ack(1);
        cl_req[1] = 1'b0;
        wait_resp();
        check("signed_data_m20", 64'(last_rdata), 64'(32'hFFFF_FFEC));

        // Round robin with both requesters held high
        run_idle(2);
        grants.delete();
        grant_cyc.delete();
        set_op(0, 32'd4, 32'd5, 4'h0, 4'h0);
        set_op(1, 32'h111, 32'h111, 4'h0, 4'h0);
        snap = 0;
        while (grants.size() < 4 && snap < 60) begin
            run_cycle();
            snap++;
        end
        cl_req = '0;
        check("rr_grants", 64'(grants.size()), 64'(4));
        if (grants.size() >= 4) begin
            check("rr_g0", 64'(grants[0]), 64'(0));
            check("rr_g1", 64'(grants[1]), 64'(1));
            check("rr_g2", 64'(grants[2]), 64'(0));
            check("rr_g3", 64'(grants[3]), 64'(1));
            for (int k = 1; k < 4; k++)
                check("rr_spacing", 64'(grant_cyc[k] - grant_cyc[k-1]), 64'(4 + L));
        end
        run_idle(10);
        check("rr_data0", 64'(rdata_by_id[0]), 64'(32'd20));
        check("rr_data1", 64'(rdata_by_id[1]), 64'(32'h0001_2321));

        // Invalid flag passes through
        set_op(0, 32'd4, 32'd5, 4'h1, 4'h0);
        wait_ack(0);
        cl_req[0] = 1'b0;
        wait_resp();
        check("inv_flag", 64'(last_rattr[INV]), 64'(1));
        check("inv_data", 64'(last_rdata), 64'(32'd20));

        // Reset during WAIT aborts the operation
        run_idle(2);
        set_op(1, 32'd7, 32'd3, 4'h0, 4'h0);
        wait_ack(1);
        cl_req[1] = 1'b0;
        run_idle(2);
        resp0 = n_resp;
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        check("rst_mid_busy", 64'(bus.busy), 64'(0));
        check("rst_mid_oe", 64'(bus.pu_signal_oe), 64'(0));
        check("rst_mid_resp_data", 64'(bus.resp_data), 64'(0));
        run_idle(10);
        check("rst_mid_no_resp", 64'(n_resp - resp0), 64'(0));
        grants.delete();
        grant_cyc.delete();
        set_op(0, 32'd6, 32'd7, 4'h0, 4'h0);
        set_op(1, 32'd8, 32'd9, 4'h0, 4'h0);
        snap = 0;
        while (grants.size() < 2 && snap < 40) begin
            run_cycle();
            cl_req = cl_req & ~obs_ack;
            snap++;
        end
        cl_req = '0;
        check("rst_after_grants", 64'(grants.size()), 64'(2));
        if (grants.size() >= 2) begin
            check("rst_after_first", 64'(grants[0]), 64'(0));
            check("rst_after_second", 64'(grants[1]), 64'(1));
        end
        run_idle(10);
        check("rst_after_data0", 64'(rdata_by_id[0]), 64'(32'd42));
        check("rst_after_data1", 64'(rdata_by_id[1]), 64'(32'd72));

        // Request dropped before acceptance, then a quiet idle stretch
        set_op(0, 32'd2, 32'd3, 4'h0, 4'h0);
        wait_ack(0);
        cl_req[0] = 1'b0;
        run_cycle();
        snap = n_ack[1];
        set_op(1, 32'd11, 32'd13, 4'h0, 4'h0);
        run_idle(2);
        cl_req[1] = 1'b0;
        run_idle(15);
        check("drop_no_ack", 64'(n_ack[1] - snap), 64'(0));
        idle_bad = 0;
        for (int k = 0; k < 20; k++) begin
            run_cycle();
            if (bus.busy || bus.pu_signal_wr || bus.pu_signal_sel || bus.pu_signal_oe ||
                bus.pu_data_in != '0 || bus.pu_attr_in != '0) idle_bad++;
        end
        check("idle_quiet", 64'(idle_bad), 64'(0));

        // Random clients
        acks0 = n_ack[0] + n_ack[1];
        resp0 = n_resp;
        for (int k = 0; k < 1500; k++) begin
            client_drive();
            run_cycle();
        end
        cl_req = '0;
        run_idle(20);
        check("rand_ack_resp_balance", 64'(n_resp - resp0), 64'(n_ack[0] + n_ack[1] - acks0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
